// File: rtl/music_note_scheduler.sv
// music_note_scheduler
// Schedules notes onto a single buzzer tone output from two sources: a FIFO of
// UART note bytes ([7:5] duration code, [4:0] tone) and a local sequencer on a
// valid/ready handshake. Each note is held for its coded duration in 1 ms ticks,
// then followed by a GAP_MS silent gap. UART notes win over local notes at note
// boundaries; byte 8'h16 is an END marker that closes the UART session.
//
// Ports:
//   sys_clk, sys_rst_n        clock, synchronous active-low reset
//   tick_1ms                  one-cycle pulse every millisecond
//   pause                     freeze playback (tone forced silent)
//   uart_done, uart_recv_data UART byte strobe (level) and received byte
//   local_valid/tone/dur      local note offer; local_ready accepts it
//   music_tone                tone to divider, 8'd22 = silence
//   busy                      playing a note or its gap
//   src_uart                  current/last note came from UART
//   uart_session              UART session active (local notes locked out)
//   fifo_level, drop_cnt      FIFO occupancy, saturating dropped-byte count
module music_note_scheduler #(
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned GAP_MS             = 10,
  parameter int unsigned SESSION_TIMEOUT_MS = 2000
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tick_1ms,
  input  logic                          pause,
  input  logic                          uart_done,
  input  logic [7:0]                    uart_recv_data,
  input  logic                          local_valid,
  input  logic [4:0]                    local_tone,
  input  logic [2:0]                    local_dur,
  output logic                          local_ready,
  output logic [7:0]                    music_tone,
  output logic                          busy,
  output logic                          src_uart,
  output logic                          uart_session,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned MS_W   = 16;
  localparam int unsigned IDLE_W = $clog2(SESSION_TIMEOUT_MS + 1);

  localparam logic [7:0] END_BYTE = 8'h16;
  localparam logic [7:0] SILENCE  = 8'd22;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t            state;
  logic [MS_W-1:0]   ms_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [4:0]        tone_q;
  logic              ready_en;

  logic              uart_d1;
  logic              uart_d2;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [7:0]        rd_data;

  logic              wr_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_ok;
  logic              pop;
  logic              local_xfer;
  logic              idle_counting;
  logic              timeout_hit;

  // Coded duration in ms.
  function automatic logic [MS_W-1:0] dur_ms(input logic [2:0] code);
    case (code)
      3'd0:    dur_ms = MS_W'(100);
      3'd1:    dur_ms = MS_W'(200);
      3'd2:    dur_ms = MS_W'(500);
      3'd3:    dur_ms = MS_W'(1000);
      3'd4:    dur_ms = MS_W'(2000);
      default: dur_ms = MS_W'(4000);
    endcase
  endfunction

  // Rising edge of the UART strobe; the write lands one edge after it is seen.
  assign wr_req     = uart_d1 & ~uart_d2;
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  // A full FIFO drops the byte even if a pop frees a slot on the same edge.
  assign wr_ok      = wr_req & ~fifo_full;
  assign pop        = (state == IDLE) & ~pause & ~fifo_empty;
  assign rd_data    = mem[rd_ptr];

  // ready_en keeps local_ready low while reset is held.
  assign local_ready = ready_en & (state == IDLE) & fifo_empty & ~uart_session & ~pause;
  assign local_xfer  = local_valid & local_ready;

  assign idle_counting = uart_session & fifo_empty & (state == IDLE) & ~wr_ok;
  assign timeout_hit   = idle_counting & tick_1ms &
                         (idle_cnt == IDLE_W'(SESSION_TIMEOUT_MS - 1));

  // Storage has no reset; the pointers alone define the contents.
  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr] <= uart_recv_data;
  end

  // Edge detect, FIFO pointers, occupancy and drop counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      uart_d1    <= 1'b0;
      uart_d2    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
    end else begin
      uart_d1 <= uart_done;
      uart_d2 <= uart_d1;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (wr_req && fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // UART session flag and its idle timeout; a non-END write wins over clears.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      uart_session <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      if (!idle_counting || timeout_hit) idle_cnt <= '0;
      else if (tick_1ms)                 idle_cnt <= idle_cnt + IDLE_W'(1);
      if (timeout_hit)                      uart_session <= 1'b0;
      if (pop && rd_data == END_BYTE)       uart_session <= 1'b0;
      if (wr_ok && uart_recv_data != END_BYTE) uart_session <= 1'b1;
    end
  end

  // Playback FSM with registered tone/busy/source outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ms_cnt     <= '0;
      tone_q     <= '0;
      music_tone <= SILENCE;
      busy       <= 1'b0;
      src_uart   <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          music_tone <= SILENCE;
          busy       <= 1'b0;
          if (pop) begin
            src_uart <= 1'b1;
            if (rd_data != END_BYTE) begin
              state      <= PLAY;
              busy       <= 1'b1;
              tone_q     <= rd_data[4:0];
              music_tone <= {3'b000, rd_data[4:0]};
              ms_cnt     <= dur_ms(rd_data[7:5]);
            end
          end else if (local_xfer) begin
            src_uart   <= 1'b0;
            state      <= PLAY;
            busy       <= 1'b1;
            tone_q     <= local_tone;
            music_tone <= {3'b000, local_tone};
            ms_cnt     <= dur_ms(local_dur);
          end
        end
        PLAY: begin
          music_tone <= pause ? SILENCE : {3'b000, tone_q};
          if (tick_1ms && !pause) begin
            if (ms_cnt == MS_W'(1)) begin
              music_tone <= SILENCE;
              if (GAP_MS == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state  <= GAP;
                ms_cnt <= MS_W'(GAP_MS);
              end
            end else begin
              ms_cnt <= ms_cnt - MS_W'(1);
            end
          end
        end
        GAP: begin
          music_tone <= SILENCE;
          if (tick_1ms && !pause) begin
            if (ms_cnt == MS_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              ms_cnt <= ms_cnt - MS_W'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          music_tone <= SILENCE;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
